// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_pkg                                                   |
// | Description : Constants and helpers shared by the UART RX and TX paths:  |
// |               parity mode encodings, default character width and FIFO   |
// |               depth, and the occupancy-counter width function.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_pkg;

    // Parity mode encodings
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Default geometry
    localparam int UART_DATA_W   = 8;
    localparam int UART_RX_DEPTH = 4;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                             |
// | Description : Single-clock FIFO with registered read port. A pop         |
// |               presents the head entry on o_rd_data one cycle later with  |
// |               a single-cycle o_rd_valid. A write is accepted when not    |
// |               full, or when full and a pop happens in the same cycle.    |
// |               Writing into an empty FIFO never falls through.            |
// | Ports       : clk, rst (async, active-high)                              |
// |               i_wr_en/i_wr_data   - push request and data                |
// |               i_rd_en             - pop request (ignored when empty)     |
// |               o_rd_data/o_rd_valid- last popped entry / update pulse     |
// |               o_count/o_full/o_empty - occupancy status                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W + 1,
    parameter int DEPTH = UART_RX_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic                      i_rd_en,
    output logic [WIDTH-1:0]          o_rd_data,
    output logic                      o_rd_valid,
    output logic [count_w(DEPTH)-1:0] o_count,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = count_w(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_rd_valid;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [c_CNT_W-1:0] w_count_nxt;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_rd_en & ~w_empty;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the write.
    assign w_push  = i_wr_en & (~w_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_valid <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + c_PTR_W'(1);
                r_rd_data <= r_mem[r_rptr];
            end
        end
    end

    // Storage carries no reset; its contents are only observed after a push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

endmodule
`default_nettype wire

// File: rtl/uart_rx_shift_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_shift_fifo                                         |
// | Description : UART receive datapath. Deserialises Rx samples strobed by  |
// |               the bit-timing FSM into a DATA_W-bit word, checks parity,  |
// |               and queues {perr, word} in a DEPTH-entry FIFO.             |
// | Ports       : CLOCK, reset (async, active-high)                          |
// |               Rx, shift, parity_sample, load_buffer - from the bit FSM   |
// |               Rd_en, clr_ovrflw                     - from the core      |
// |               rx_data_out, rx_perr, rd_valid        - popped word        |
// |               d_valid, fifo_count, overflow         - FIFO status        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_shift_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int DEPTH      = UART_RX_DEPTH,
    parameter int LSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic                      CLOCK,
    input  logic                      reset,
    input  logic                      Rx,
    input  logic                      shift,
    input  logic                      parity_sample,
    input  logic                      load_buffer,
    input  logic                      Rd_en,
    input  logic                      clr_ovrflw,
    output logic [DATA_W-1:0]         rx_data_out,
    output logic                      rx_perr,
    output logic                      rd_valid,
    output logic                      d_valid,
    output logic [count_w(DEPTH)-1:0] fifo_count,
    output logic                      overflow
);

    logic [DATA_W-1:0] r_sreg;
    logic              r_par_bit;
    logic              r_overflow;

    logic [DATA_W-1:0] w_sreg_shifted;
    logic              w_perr;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;
    logic [DATA_W:0]   w_rd_entry;

    if (LSB_FIRST != 0) begin : g_lsb_first
        assign w_sreg_shifted = {Rx, r_sreg[DATA_W-1:1]};
    end else begin : g_msb_first
        assign w_sreg_shifted = {r_sreg[DATA_W-2:0], Rx};
    end

    // The pushed value is the register contents before any same-cycle shift,
    // so the FSM may overlap the next frame's first shift with load_buffer.
    assign w_perr = (PARITY_EN != 0) &&
                    (((^r_sreg) ^ r_par_bit) != 1'(PARITY_ODD));

    // When full, any Rd_en is a real pop (full implies non-empty), which
    // makes room for the incoming word.
    assign w_ovf_set = load_buffer & w_full & ~Rd_en;

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_sreg     <= '0;
            r_par_bit  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (shift) begin
                r_sreg <= w_sreg_shifted;
            end
            if (parity_sample) begin
                r_par_bit <= Rx;
            end
            // Set has priority over clear so a drop is never lost.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_ovrflw) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLOCK),
        .rst        (reset),
        .i_wr_en    (load_buffer),
        .i_wr_data  ({w_perr, r_sreg}),
        .i_rd_en    (Rd_en),
        .o_rd_data  (w_rd_entry),
        .o_rd_valid (rd_valid),
        .o_count    (fifo_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign rx_data_out = w_rd_entry[DATA_W-1:0];
    assign rx_perr     = w_rd_entry[DATA_W];
    assign d_valid     = ~w_empty;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_shift_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_shift_fifo                                      |
// | Description : Self-checking bench. Three configurations share stimulus:  |
// |               u0 = 8b LSB-first even parity, u1 = 7b MSB-first odd       |
// |               parity, u2 = defaults (8b LSB-first, no parity). A queue-  |
// |               based reference model predicts every output each cycle.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_shift_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, Rx, shift, parity_sample, load_buffer, Rd_en, clr_ovrflw;

    logic [7:0] dout0, dout2;
    logic [6:0] dout1;
    logic       perr0, perr1, perr2;
    logic       rdv0, rdv1, rdv2;
    logic       dv0, dv1, dv2;
    logic [2:0] cnt0, cnt1, cnt2;
    logic       ovf0, ovf1, ovf2;

    uart_rx_shift_fifo #(.DATA_W(8), .DEPTH(4), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
        .CLOCK(clk), .reset(reset), .Rx(Rx), .shift(shift), .parity_sample(parity_sample),
        .load_buffer(load_buffer), .Rd_en(Rd_en), .clr_ovrflw(clr_ovrflw),
        .rx_data_out(dout0), .rx_perr(perr0), .rd_valid(rdv0), .d_valid(dv0),
        .fifo_count(cnt0), .overflow(ovf0));

    uart_rx_shift_fifo #(.DATA_W(7), .DEPTH(4), .LSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .CLOCK(clk), .reset(reset), .Rx(Rx), .shift(shift), .parity_sample(parity_sample),
        .load_buffer(load_buffer), .Rd_en(Rd_en), .clr_ovrflw(clr_ovrflw),
        .rx_data_out(dout1), .rx_perr(perr1), .rd_valid(rdv1), .d_valid(dv1),
        .fifo_count(cnt1), .overflow(ovf1));

    uart_rx_shift_fifo u2 (
        .CLOCK(clk), .reset(reset), .Rx(Rx), .shift(shift), .parity_sample(parity_sample),
        .load_buffer(load_buffer), .Rd_en(Rd_en), .clr_ovrflw(clr_ovrflw),
        .rx_data_out(dout2), .rx_perr(perr2), .rd_valid(rdv2), .d_valid(dv2),
        .fifo_count(cnt2), .overflow(ovf2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_w(input int k);    return (k == 1) ? 7 : 8; endfunction
    function automatic bit m_lsbf(input int k); return (k != 1);         endfunction
    function automatic bit m_pen(input int k);  return (k != 2);         endfunction
    function automatic int m_odd(input int k);  return (k == 1) ? 1 : 0; endfunction

    bit         hist [9];      // last nine shifted-in bits, hist[8] newest
    bit         m_par;
    logic [9:0] mq   [3][$];   // {perr, word}
    logic [8:0] m_out [3];
    bit         m_perr [3];
    bit         m_rdv  [3];
    bit         m_ovf  [3];

    task automatic model_reset();
        for (int i = 0; i < 9; i++) hist[i] = 1'b0;
        m_par = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_out[k] = '0; m_perr[k] = 1'b0; m_rdv[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    // Word formed by the most recent m_w(k) received bits.
    function automatic logic [8:0] mword(input int k);
        logic [8:0] w = '0;
        for (int i = 0; i < m_w(k); i++) begin
            if (m_lsbf(k)) w[m_w(k) - 1 - i] = hist[8 - i];
            else           w[i]              = hist[8 - i];
        end
        return w;
    endfunction

    function automatic bit mperr(input int k, input logic [8:0] w);
        int ones = $countones(w) + int'(m_par);
        return m_pen(k) && ((ones % 2) != m_odd(k));
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [8:0] w;
            bit pop, push, ovf_set;
            logic [9:0] e;
            w       = mword(k);
            pop     = Rd_en && (mq[k].size() > 0);
            push    = load_buffer && ((mq[k].size() < 4) || pop);
            ovf_set = load_buffer && (mq[k].size() == 4) && !pop;
            m_rdv[k] = pop;
            if (pop) begin
                e = mq[k].pop_front();
                m_out[k]  = e[8:0];
                m_perr[k] = e[9];
            end
            if (push) mq[k].push_back({mperr(k, w), w});
            if (ovf_set)         m_ovf[k] = 1'b1;
            else if (clr_ovrflw) m_ovf[k] = 1'b0;
        end
        if (shift) begin
            for (int i = 0; i < 8; i++) hist[i] = hist[i + 1];
            hist[8] = Rx;
        end
        if (parity_sample) m_par = Rx;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            logic [8:0] d;
            logic p, v, dv, o;
            logic [2:0] c;
            case (k)
                0:       begin d = {1'b0, dout0}; p = perr0; v = rdv0; dv = dv0; c = cnt0; o = ovf0; end
                1:       begin d = {2'b0, dout1}; p = perr1; v = rdv1; dv = dv1; c = cnt1; o = ovf1; end
                default: begin d = {1'b0, dout2}; p = perr2; v = rdv2; dv = dv2; c = cnt2; o = ovf2; end
            endcase
            check($sformatf("u%0d.data", k),  32'(d),  32'(m_out[k]));
            check($sformatf("u%0d.perr", k),  32'(p),  32'(m_perr[k]));
            check($sformatf("u%0d.rdv", k),   32'(v),  32'(m_rdv[k]));
            check($sformatf("u%0d.dvalid", k), 32'(dv), 32'(mq[k].size() != 0));
            check($sformatf("u%0d.count", k), 32'(c),  32'(mq[k].size()));
            check($sformatf("u%0d.ovf", k),   32'(o),  32'(m_ovf[k]));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input bit sh, input bit ps, input bit rx, input bit ld, input bit rd, input bit clr);
        shift = sh; parity_sample = ps; Rx = rx; load_buffer = ld; Rd_en = rd; clr_ovrflw = clr;
        @(posedge clk);
        model_step();
        #1 compare_all();
        @(negedge clk);
    endtask

    task automatic send_lsb8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) cyc(1, 0, v[i], 0, 0, 0);
    endtask

    task automatic async_reset();
        shift = 0; parity_sample = 0; load_buffer = 0; Rd_en = 0; clr_ovrflw = 0; Rx = 0;
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();          // before any clock edge: reset is asynchronous
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Rx = 0; shift = 0; parity_sample = 0; load_buffer = 0; Rd_en = 0; clr_ovrflw = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Basic frame: 1,0,1,0,0,1,0,1 LSB first -> A5
        send_lsb8(8'hA5);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("basic.a5", 32'(dout2), 32'h0A5);
        check("basic.rdv", 32'(rdv2), 32'd1);
        check("basic.dvalid", 32'(dv2), 32'd0);
        check("basic.count", 32'(cnt2), 32'd0);

        // Fill, overflow, drain, clear
        send_lsb8(8'h11); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h22); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h33); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h44); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h55); cyc(0, 0, 0, 1, 0, 0);
        check("ovf.flag", 32'(ovf2), 32'd1);
        check("ovf.count", 32'(cnt2), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            check("ovf.order", 32'(dout2), 32'h11 * (i + 1));
        end
        cyc(0, 0, 0, 0, 0, 1);
        check("ovf.clr", 32'(ovf2), 32'd0);

        // Full FIFO with simultaneous push and pop
        send_lsb8(8'h61); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h62); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h63); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h64); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'h65); cyc(0, 0, 0, 1, 1, 0);
        check("fullrw.data", 32'(dout2), 32'h61);
        check("fullrw.count", 32'(cnt2), 32'd4);
        check("fullrw.ovf", 32'(ovf2), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        check("fullrw.last", 32'(dout2), 32'h65);

        // Parity on u0 (even): 0x07 has three ones
        send_lsb8(8'h07); cyc(0, 1, 1, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        check("par.ok", 32'(perr0), 32'd0);
        send_lsb8(8'h07); cyc(0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        check("par.bad", 32'(perr0), 32'd1);

        // u1 (MSB first, 7 bits): 1,0,0,0,0,0,1 -> 41
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("msb.41", 32'(dout1), 32'h41);
        cyc(0, 0, 0, 0, 1, 0);     // read while empty
        check("empty.rdv", 32'(rdv1), 32'd0);
        check("empty.hold", 32'(dout1), 32'h41);

        // Reset mid-frame with two entries queued
        send_lsb8(8'h3C); cyc(0, 0, 0, 1, 0, 0);
        send_lsb8(8'hC3); cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0, 0); cyc(1, 0, 1, 0, 0, 0);
        async_reset();
        cyc(0, 0, 0, 0, 1, 0);
        check("rst.rdv", 32'(rdv2), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 900; i++) begin
            bit drain;
            drain = ((i / 120) % 2) == 1;
            if (i == 450) async_reset();
            cyc(($urandom_range(0, 1) == 1),
                ($urandom_range(0, 7) == 0),
                1'($urandom),
                ($urandom_range(0, 4) == 0),
                drain ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_shift_fifo.md
Name: uart_rx_shift_fifo

Overview:
- Receive-side datapath for the UART RX path.
- Deserialises bit samples from the RX bit-timing FSM into a DATA_W-bit word with configurable bit order and optional parity check.
- Queues completed words in a DEPTH-entry FIFO so the core can drain bursts without losing characters.
- Replaces the single-buffer RX register; the strobe interface to the bit FSM is unchanged.

Parameters:
- DATA_W, 8: character width in bits; legal range 5..9.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- LSB_FIRST, 1: 1 = first received bit lands in bit 0 (standard UART); 0 = MSB first.
- PARITY_EN, 0: 1 = check the parity bit captured via parity_sample.
- PARITY_ODD, 0: 1 = odd parity expected; 0 = even.

Ports:
- CLOCK  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rx  in  1  synchronised serial data sample.
- shift  in  1  one-cycle strobe: shift Rx into the shift register.
- parity_sample  in  1  one-cycle strobe: capture Rx as the parity bit.
- load_buffer  in  1  one-cycle strobe: frame complete, push the word.
- Rd_en  in  1  pop request from the core.
- clr_ovrflw  in  1  clear the sticky overflow flag.
- rx_data_out  out  DATA_W  last popped word.
- rx_perr  out  1  parity error flag of the last popped word.
- rd_valid  out  1  one-cycle pulse: rx_data_out/rx_perr were updated this cycle.
- d_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (async, on reset high): shift register, parity bit, read/write pointers, count and all FIFO flags go to 0. rx_data_out=0, rx_perr=0, rd_valid=0, d_valid=0, fifo_count=0, overflow=0. FIFO memory contents are don't-care. Reset mid-frame discards the partial word.
- Shift: on shift high:
  - LSB_FIRST=1: sreg <= {Rx, sreg[DATA_W-1:1]}.
  - LSB_FIRST=0: sreg <= {sreg[DATA_W-2:0], Rx}.
  - The shift register is never cleared between frames; a frame is exactly DATA_W shifts.
- Parity capture: on parity_sample high, par_bit <= Rx.
- Parity error: perr = PARITY_EN & ((^sreg ^ par_bit) != PARITY_ODD); forced to 0 when PARITY_EN=0.
- Push: load_buffer high, FIFO not full → mem[wptr] <= {perr, sreg}, wptr++, count++.
  - If shift and load_buffer are high in the same cycle, the pushed value is sreg before that shift.
- Pop: Rd_en high, FIFO not empty → {rx_perr, rx_data_out} <= mem[rptr], rptr++, count--, rd_valid=1 for one cycle. Read latency is 1 cycle from Rd_en.
- Rd_en while empty: ignored. Outputs hold their values, rd_valid=0, no underflow flag.
- Push and pop in the same cycle:
  - Non-empty, not full: both occur, count unchanged.
  - Full: both occur; the pop frees the slot, so no overflow.
  - Empty: push only, no fall-through; the word can be popped from the next cycle.
- Overflow: load_buffer high while full and Rd_en low (or Rd_en high with the FIFO empty, impossible when full) → word dropped, overflow <= 1, FIFO contents and pointers unchanged.
  - clr_ovrflw clears overflow.
  - If a set and clr_ovrflw occur in the same cycle, set wins.
- Pointers: log2(DEPTH) bits, natural wrap. full = (count==DEPTH); empty = (count==0).
- d_valid and fifo_count are registered, updated in the same edge as count.
- No state machine beyond the FIFO occupancy; the bit FSM owns frame timing.

Decomposition:
- Shared package uart_pkg:
  - parity mode constants PAR_EVEN=0, PAR_ODD=1;
  - default UART_DATA_W=8 and UART_RX_DEPTH=4;
  - a width function for count ($clog2(DEPTH+1)), shared with the TX FIFO.
- One sub-module: uart_sync_fifo, parametrised width DATA_W+1 and DEPTH.
  - Owns the memory, pointers, count, full/empty and registered read output.
  - Reused by the TX path.
- The top level holds the shift register, parity logic and overflow flag.

Test Plan:
- Default params, LSB_FIRST=1: shift in bits 1,0,1,0,0,1,0,1 (first to last), then load_buffer, then Rd_en → next cycle rx_data_out=8'hA5, rd_valid=1, d_valid=0, fifo_count=0.
- DEPTH=4: push 0x11,0x22,0x33,0x44 (full), push 0x55 → overflow=1, fifo_count=4; pop ×4 yields 0x11..0x44 in order; clr_ovrflw → overflow=0.
- Full FIFO: load_buffer and Rd_en in the same cycle → pop returns the oldest entry, new word is stored, overflow stays 0, fifo_count stays 4.
- PARITY_EN=1, PARITY_ODD=0:
  - data 0x07 with par_bit=1 → rx_perr=0.
  - data 0x07 with par_bit=0 → rx_perr=1.
  - With PARITY_ODD=1, the rx_perr results invert.
- LSB_FIRST=0, DATA_W=7: shift 1,0,0,0,0,0,1 → popped word 7'h41. Rd_en on empty → no rd_valid, rx_data_out unchanged.
- Assert reset mid-frame with 2 entries queued → all outputs 0 immediately (async); after release, Rd_en yields no rd_valid.
